pkt_ctrl_tdma: RTL and testbench

Parametrised next-generation node controller for the EER-RL cluster protocol.
- Decodes each validated incoming packet into one-cycle enable pulses for KCH, MNI, QTU/FMB, neighbour table and reward blocks.
- Adds a TDMA slot counter and a carrier-sense/random-backoff transmit FSM.
- Sits between the packet parser and the node's memory/learning blocks, and gates the radio TX path.

---
 rtl/pkt_ctrl_tdma.sv | 179 +++++++++++++++++
 tb/tb_pkt_ctrl_tdma.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pkt_ctrl_tdma.sv
// EER-RL node controller: registered packet decode pulses, TDMA slot counter,
// and a carrier-sense / random-backoff transmit FSM that gates the radio.
module pkt_ctrl_tdma #(
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_SLOTS    = 8,
  parameter int MAX_HOPS     = 4,
  parameter int CCA_CYCLES   = 4,
  parameter int MAX_RETRIES  = 3,
  parameter int BACKOFF_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  role,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic                  iHaveData,
  input  logic                  channel_clear,
  input  logic                  slot_tick,
  input  logic [WORD_WIDTH-1:0] myTimeslot,
  input  logic                  tx_done,
  output logic                  en_KCH,
  output logic                  en_MNI,
  output logic                  en_QTU_FMB,
  output logic                  en_neighborTable,
  output logic                  en_reward,
  output logic                  iAmDestination,
  output logic                  okToSend,
  output logic                  tx_fail,
  output logic [WORD_WIDTH-1:0] slot_cnt
);

  localparam int CW = (CCA_CYCLES > 1) ? $clog2(CCA_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BW = BACKOFF_BITS + 1;
  localparam logic [CW-1:0]         CCA_LAST  = CW'(CCA_CYCLES - 1);
  localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [WORD_WIDTH-1:0] SLOT_LAST = WORD_WIDTH'(NUM_SLOTS - 1);
  localparam logic [WORD_WIDTH-1:0] HOPS_LIM  = WORD_WIDTH'(MAX_HOPS);

  typedef enum logic [2:0] {
    IDLE, WAIT_SLOT, SENSE, BACKOFF, SEND, FAIL
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cca_q, cca_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [BW-1:0]           bo_q, bo_d;
  logic [WORD_WIDTH-1:0]   slot_q, slot_d, slot_nxt;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [5:0]              dec_q, dec_d;
  logic [BW-1:0]           bo_load;
  logic                    in_slot;
  logic                    match, dest;
  logic                    t_hb, t_che, t_inv, t_mr, t_cht, t_data, t_sos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cca_q   <= '0;
      retry_q <= '0;
      bo_q    <= '0;
      slot_q  <= '0;
      lfsr_q  <= 16'hACE1;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      cca_q   <= cca_d;
      retry_q <= retry_d;
      bo_q    <= bo_d;
      slot_q  <= slot_d;
      lfsr_q  <= lfsr_d;
      dec_q   <= dec_d;
    end
  end

  // Packet decode; reserved type 111 matches no flag so everything stays low
  always_comb begin
    match  = (fChosenCH == chosenCH);
    dest   = (destinationID == myNodeID);
    t_hb   = (fPacketType == 3'b000);
    t_che  = (fPacketType == 3'b001);
    t_inv  = (fPacketType == 3'b010);
    t_mr   = (fPacketType == 3'b011);
    t_cht  = (fPacketType == 3'b100);
    t_data = (fPacketType == 3'b101);
    t_sos  = (fPacketType == 3'b110);
    dec_d  = '0;
    if (pkt_valid) begin
      dec_d[5] = t_inv;
      dec_d[4] = t_hb | t_che | (t_cht & dest);
      dec_d[3] = (t_mr | t_data | t_sos) & match;
      dec_d[2] = (t_mr | t_data | t_sos) & match;
      dec_d[1] = t_hb
               | (t_inv & (fHopsFromCH < HOPS_LIM))
               | ((t_mr | t_cht) & role)
               | ((t_data | t_sos) & (dest | iHaveData));
      dec_d[0] = dest & (fPacketType != 3'b111);
    end
  end

  always_comb begin
    slot_nxt = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    slot_d   = slot_tick ? slot_nxt : slot_q;
    in_slot  = (slot_q == myTimeslot);
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    bo_load  = {1'b0, lfsr_q[BACKOFF_BITS-1:0]} + BW'(1);
  end

  always_comb begin
    state_d = state_q;
    cca_d   = cca_q;
    retry_d = retry_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        retry_d = '0;
        cca_d   = '0;
        if (iHaveData) state_d = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (!iHaveData) begin
          state_d = IDLE;
        end else if (in_slot) begin
          state_d = SENSE;
          cca_d   = '0;
        end
      end
      SENSE: begin
        // Slot exit outranks both the clear and busy outcomes
        if (slot_tick && (slot_nxt != myTimeslot)) begin
          state_d = WAIT_SLOT;
          cca_d   = '0;
        end else if (channel_clear) begin
          if (cca_q == CCA_LAST) state_d = SEND;
          else                   cca_d   = cca_q + 1'b1;
        end else if (retry_q == RETRY_MAX) begin
          state_d = FAIL;
        end else begin
          retry_d = retry_q + 1'b1;
          bo_d    = bo_load;
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        if (!in_slot) begin
          state_d = WAIT_SLOT;
          cca_d   = '0;
        end else if (bo_q == BW'(1)) begin
          state_d = SENSE;
          cca_d   = '0;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      SEND: begin
        if (tx_done) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      FAIL: begin
        state_d = IDLE;
        retry_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination} = dec_q;
  assign okToSend = (state_q == SEND);
  assign tx_fail  = (state_q == FAIL);
  assign slot_cnt = slot_q;

endmodule

// File: tb/tb_pkt_ctrl_tdma.sv
// Directed bench for pkt_ctrl_tdma: decode pulses, slot counter, TX FSM and reset abort.
module tb_pkt_ctrl_tdma;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pkt_valid;
  logic [2:0]   fPacketType;
  logic [W-1:0] fHopsFromCH, fChosenCH, destinationID, myNodeID, chosenCH, myTimeslot;
  logic         role, iHaveData, channel_clear, slot_tick, tx_done;
  logic         en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination;
  logic         okToSend, tx_fail;
  logic [W-1:0] slot_cnt;
  logic [5:0]   dec;

  int errors = 0;
  int checks = 0;
  int n;
  bit saw;

  pkt_ctrl_tdma #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fPacketType(fPacketType),
    .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .destinationID(destinationID),
    .myNodeID(myNodeID), .role(role), .chosenCH(chosenCH), .iHaveData(iHaveData),
    .channel_clear(channel_clear), .slot_tick(slot_tick), .myTimeslot(myTimeslot),
    .tx_done(tx_done), .en_KCH(en_KCH), .en_MNI(en_MNI), .en_QTU_FMB(en_QTU_FMB),
    .en_neighborTable(en_neighborTable), .en_reward(en_reward),
    .iAmDestination(iAmDestination), .okToSend(okToSend), .tx_fail(tx_fail),
    .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  assign dec = {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input logic [2:0] t, input logic [W-1:0] hops, input logic [W-1:0] cch,
                     input logic [W-1:0] dst);
    pkt_valid     = 1'b1;
    fPacketType   = t;
    fHopsFromCH   = hops;
    fChosenCH     = cch;
    destinationID = dst;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; fPacketType = '0; fHopsFromCH = '0; fChosenCH = '0;
    destinationID = '0; myNodeID = 16'd9; role = 1'b1; chosenCH = 16'd5; iHaveData = 1'b0;
    channel_clear = 1'b0; slot_tick = 1'b0; myTimeslot = 16'd2; tx_done = 1'b0;
    repeat (2) tick();
    chk("reset_dec", {26'd0, dec}, 32'h0);
    chk("reset_ok", {31'd0, okToSend}, 32'h0);
    chk("reset_fail", {31'd0, tx_fail}, 32'h0);
    chk("reset_slot", {16'd0, slot_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    // decode vectors, each checked the cycle after sampling
    pkt(3'b011, 16'd0, 16'd5, 16'd0); chk("mr_match", {26'd0, dec}, 32'b001110);
    pkt(3'b011, 16'd0, 16'd6, 16'd0); chk("mr_nomatch", {26'd0, dec}, 32'b000010);
    pkt(3'b010, 16'd3, 16'd6, 16'd0); chk("inv_h3", {26'd0, dec}, 32'b100010);
    pkt(3'b010, 16'd4, 16'd6, 16'd0); chk("inv_h4", {26'd0, dec}, 32'b100000);
    role = 1'b0;
    pkt(3'b100, 16'd0, 16'd6, 16'd9); chk("cht_dest", {26'd0, dec}, 32'b010001);
    pkt_valid = 1'b0; tick();         chk("no_valid", {26'd0, dec}, 32'b000000);
    pkt(3'b000, 16'd0, 16'd6, 16'd9); chk("hb_dest", {26'd0, dec}, 32'b010011);
    pkt(3'b111, 16'd0, 16'd5, 16'd9); chk("reserved", {26'd0, dec}, 32'b000000);
    pkt(3'b101, 16'd0, 16'd5, 16'd0); chk("data_nodest", {26'd0, dec}, 32'b001100);
    pkt_valid = 1'b0; tick();         chk("pulse_end", {26'd0, dec}, 32'b000000);

    // clear channel, slot 2 reached by two ticks
    myTimeslot = 16'd2; iHaveData = 1'b1; channel_clear = 1'b1; slot_tick = 1'b1;
    tick(); tick();
    slot_tick = 1'b0;
    chk("slot_two", {16'd0, slot_cnt}, 32'd2);
    chk("ok_before", {31'd0, okToSend}, 32'h0);
    n = 0;
    while (!okToSend && n < 40) begin tick(); n++; end
    chk("clear_latency", n, 32'd5);
    slot_tick = 1'b1; channel_clear = 1'b0; tick(); slot_tick = 1'b0;
    chk("send_holds", {31'd0, okToSend}, 32'h1);
    tx_done = 1'b1; iHaveData = 1'b0; tick(); tx_done = 1'b0;
    chk("send_done", {31'd0, okToSend}, 32'h0);
    tick();
    chk("idle_stays", {31'd0, okToSend}, 32'h0);

    // busy on first sense, then released
    myTimeslot = 16'd3; iHaveData = 1'b1; channel_clear = 1'b0;
    repeat (3) tick();
    chk("backoff_no_send", {31'd0, okToSend}, 32'h0);
    channel_clear = 1'b1;
    n = 0;
    while (!okToSend && n < 40) begin tick(); n++; end
    chk("backoff_range", {31'd0, (n >= 5 && n <= 20)}, 32'h1);
    tx_done = 1'b1; iHaveData = 1'b0; tick(); tx_done = 1'b0;
    chk("backoff_done", {31'd0, okToSend}, 32'h0);

    // permanently busy: three backoffs then failure
    iHaveData = 1'b1; channel_clear = 1'b0; n = 0; saw = 1'b0;
    while (!tx_fail && n < 100) begin
      tick(); n++;
      if (okToSend) saw = 1'b1;
    end
    iHaveData = 1'b0;
    chk("fail_range", {31'd0, (n >= 9 && n <= 54)}, 32'h1);
    chk("fail_no_send", {31'd0, saw}, 32'h0);
    tick();
    chk("fail_one_cycle", {31'd0, tx_fail}, 32'h0);

    slot_tick = 1'b1;
    repeat (4) tick();
    chk("slot_seven", {16'd0, slot_cnt}, 32'd7);
    tick();
    chk("slot_wrap", {16'd0, slot_cnt}, 32'd0);

    // unreachable timeslot never grants the channel
    myTimeslot = 16'd9; iHaveData = 1'b1; channel_clear = 1'b1; saw = 1'b0;
    repeat (20) begin tick(); if (okToSend) saw = 1'b1; end
    slot_tick = 1'b0; iHaveData = 1'b0; tick();
    chk("bad_slot", {31'd0, saw}, 32'h0);
    chk("slot_after", {16'd0, slot_cnt}, 32'd4);

    // reset in the middle of SEND
    myTimeslot = 16'd4; iHaveData = 1'b1; channel_clear = 1'b1; n = 0;
    while (!okToSend && n < 40) begin tick(); n++; end
    chk("send_latency", n, 32'd6);
    slot_tick = 1'b1; tick(); slot_tick = 1'b0;
    chk("pre_rst_slot", {16'd0, slot_cnt}, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ok", {31'd0, okToSend}, 32'h0);
    chk("rst_async_slot", {16'd0, slot_cnt}, 32'd0);
    iHaveData = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", {31'd0, okToSend}, 32'h0);
    chk("post_rst_slot", {16'd0, slot_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
